// File: rtl/axis_packed_frame_arb_pkg.sv
// Shared definitions for the packed-stream frame arbiter: packed bit map,
// arbiter state encoding and the packed-width helper.
package axis_packed_frame_arb_pkg;

  localparam int PK_EOL = 0;
  localparam int PK_SOF = 1;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_PASS = 1'b1
  } arb_state_e;

  function automatic int packed_width(input int tdata_width);
    return tdata_width + 2;
  endfunction

endpackage

// File: rtl/axis_packed_frame_arb_packed_out_reg.sv
// Output valid/data register for a packed stream; it can take a new beat
// whenever the downstream is ready or the register is empty.
module packed_out_reg #(
  parameter int PW = 34
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [PW-1:0] i_data,
  input  logic          i_m_tready,
  output logic          o_ready,
  output logic          o_m_tvalid,
  output logic [PW-1:0] o_m_tpacked
);

  logic          valid_q, valid_d;
  logic [PW-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (i_load) begin
      valid_d = 1'b1;
      data_d  = i_data;
    end else if (valid_q && i_m_tready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign o_ready     = i_m_tready || !valid_q;
  assign o_m_tvalid  = valid_q;
  assign o_m_tpacked = data_q;

endmodule

// File: rtl/axis_packed_frame_arb.sv
// Frame-granular 2:1 round-robin arbiter for packed {data, sof, eol} streams.
// Define PACKED_ARB_SOF_CHECK_EN to flag and restart on a mid-frame SOF.
module axis_packed_frame_arb
  import axis_packed_frame_arb_pkg::*;
#(
  parameter  int TDATA_WIDTH = 32,
  parameter  int FRAME_LINES = 480,
  localparam int PW          = packed_width(TDATA_WIDTH),
  localparam int LW          = $clog2(FRAME_LINES)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_s0_tvalid,
  output logic          o_s0_tready,
  input  logic [PW-1:0] i_s0_tpacked,
  input  logic          i_s1_tvalid,
  output logic          o_s1_tready,
  input  logic [PW-1:0] i_s1_tpacked,
  output logic          o_m_tvalid,
  input  logic          i_m_tready,
  output logic [PW-1:0] o_m_tpacked,
  output logic          o_grant,
  output logic          o_busy,
  output logic [LW-1:0] o_line_cnt,
  output logic          o_frame_done,
  output logic          o_drop,
  output logic          o_err
);

  localparam logic [LW-1:0] LAST_LINE = LW'(FRAME_LINES - 1);

  arb_state_e    state_q, state_d;
  logic          grant_q, grant_d;
  logic          rr_q, rr_d;
  logic [LW-1:0] line_cnt_q, line_cnt_d;
  logic          frame_done_q, frame_done_d;
  logic          drop_q, drop_d;
  logic          req0, req1, src_valid, out_ready, accept, load;
  logic [PW-1:0] src_data;
  logic [LW-1:0] cnt_base;
`ifdef PACKED_ARB_SOF_CHECK_EN
  logic          err_q, err_d;
  logic          first_q, first_d;
`endif

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_d         = rr_q;
    line_cnt_d   = line_cnt_q;
    frame_done_d = 1'b0;
    drop_d       = 1'b0;
    o_s0_tready  = 1'b0;
    o_s1_tready  = 1'b0;
    accept       = 1'b0;
    load         = 1'b0;
    cnt_base     = line_cnt_q;
    req0         = i_s0_tvalid && i_s0_tpacked[PK_SOF];
    req1         = i_s1_tvalid && i_s1_tpacked[PK_SOF];
    src_valid    = grant_q ? i_s1_tvalid : i_s0_tvalid;
    src_data     = grant_q ? i_s1_tpacked : i_s0_tpacked;
`ifdef PACKED_ARB_SOF_CHECK_EN
    err_d        = 1'b0;
    first_d      = first_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        // Heads without SOF are flushed so every grant starts on a frame boundary.
        o_s0_tready = i_s0_tvalid && !i_s0_tpacked[PK_SOF];
        o_s1_tready = i_s1_tvalid && !i_s1_tpacked[PK_SOF];
        drop_d      = o_s0_tready || o_s1_tready;
        if (req0 || req1) begin
          state_d = ARB_PASS;
          grant_d = (req0 && req1) ? rr_q : req1;
`ifdef PACKED_ARB_SOF_CHECK_EN
          first_d = 1'b1;
`endif
        end
      end
      ARB_PASS: begin
        if (grant_q) o_s1_tready = out_ready;
        else         o_s0_tready = out_ready;
        accept = src_valid && out_ready;
        load   = accept;
        if (accept) begin
`ifdef PACKED_ARB_SOF_CHECK_EN
          first_d = 1'b0;
          if (src_data[PK_SOF] && !first_q) begin
            err_d    = 1'b1;
            cnt_base = '0;
          end
`endif
          line_cnt_d = cnt_base;
          if (src_data[PK_EOL]) begin
            if (cnt_base == LAST_LINE) begin
              line_cnt_d   = '0;
              frame_done_d = 1'b1;
              state_d      = ARB_IDLE;
              rr_d         = !grant_q;
            end else begin
              line_cnt_d = cnt_base + LW'(1);
            end
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ARB_IDLE;
      grant_q      <= 1'b0;
      rr_q         <= 1'b0;
      line_cnt_q   <= '0;
      frame_done_q <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_q         <= rr_d;
      line_cnt_q   <= line_cnt_d;
      frame_done_q <= frame_done_d;
      drop_q       <= drop_d;
    end
  end

`ifdef PACKED_ARB_SOF_CHECK_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      err_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      err_q   <= err_d;
      first_q <= first_d;
    end
  end
  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  packed_out_reg #(.PW(PW)) u_out_reg (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (load),
    .i_data      (src_data),
    .i_m_tready  (i_m_tready),
    .o_ready     (out_ready),
    .o_m_tvalid  (o_m_tvalid),
    .o_m_tpacked (o_m_tpacked)
  );

  assign o_grant      = grant_q;
  assign o_busy       = (state_q == ARB_PASS);
  assign o_line_cnt   = line_cnt_q;
  assign o_frame_done = frame_done_q;
  assign o_drop       = drop_q;

endmodule

// File: tb/tb_axis_packed_frame_arb.sv
// Directed bench for axis_packed_frame_arb with TDATA_WIDTH=8, FRAME_LINES=2;
// the mid-frame SOF expectations follow PACKED_ARB_SOF_CHECK_EN.
module tb_axis_packed_frame_arb;

  localparam int TW = 8;
  localparam int FL = 2;
  localparam int PW = TW + 2;
  localparam int LW = 1;

  logic          clk, rst;
  logic          s0Valid, s0Ready, s1Valid, s1Ready;
  logic [PW-1:0] s0Packed, s1Packed;
  logic          mValid, mReady;
  logic [PW-1:0] mPacked;
  logic          grant, busy, frameDone, drop, err;
  logic [LW-1:0] lineCnt;

  int checks = 0;
  int errors = 0;
  int dropCnt = 0;
  int doneCnt = 0;
  logic [PW-1:0] monQ[$];

  axis_packed_frame_arb #(.TDATA_WIDTH(TW), .FRAME_LINES(FL)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_s0_tvalid  (s0Valid),
    .o_s0_tready  (s0Ready),
    .i_s0_tpacked (s0Packed),
    .i_s1_tvalid  (s1Valid),
    .o_s1_tready  (s1Ready),
    .i_s1_tpacked (s1Packed),
    .o_m_tvalid   (mValid),
    .i_m_tready   (mReady),
    .o_m_tpacked  (mPacked),
    .o_grant      (grant),
    .o_busy       (busy),
    .o_line_cnt   (lineCnt),
    .o_frame_done (frameDone),
    .o_drop       (drop),
    .o_err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records every beat the kernel consumes plus pulse counts, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (mValid && mReady) monQ.push_back(mPacked);
      if (drop) dropCnt++;
      if (frameDone) doneCnt++;
    end
  end

  function automatic logic [PW-1:0] pk(input logic [7:0] d, input logic s, input logic e);
    return {d, s, e};
  endfunction

  task automatic doReset();
    rst = 1'b1;
    s0Valid = 1'b0; s1Valid = 1'b0;
    s0Packed = '0;  s1Packed = '0;
    mReady = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Presents a beat on one source and returns #1 after the edge that accepted it.
  task automatic applyStimulus(input int src, input logic [PW-1:0] beat);
    int n;
    n = 0;
    if (src == 0) begin s0Valid = 1'b1; s0Packed = beat; end
    else          begin s1Valid = 1'b1; s1Packed = beat; end
    @(negedge clk);
    while (((src == 0) ? !s0Ready : !s1Ready) && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("[TB] FAIL accept_timeout: src %0d got no tready, required within 50 cycles", src);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s0Valid = 1'b0; s1Valid = 1'b0; mReady = 1'b1;
    #1;
    checks++;
    if ({mValid, mPacked, lineCnt, grant, busy, frameDone, drop, err} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b required all zero",
               {mValid, mPacked, lineCnt, grant, busy, frameDone, drop, err});
    end
    doReset();
  endtask

  task automatic test_single();
    logic [PW-1:0] beats[4];
    logic [LW-1:0] expCnt[4];
    int doneBase;
    doReset();
    doneBase = doneCnt;
    beats[0] = pk(8'hA1, 1, 0); beats[1] = pk(8'hA2, 0, 1);
    beats[2] = pk(8'hA3, 0, 0); beats[3] = pk(8'hA4, 0, 1);
    expCnt[0] = 0; expCnt[1] = 1; expCnt[2] = 1; expCnt[3] = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, beats[i]);
      checks++;
      if (mValid !== 1'b1 || mPacked !== beats[i]) begin
        errors++;
        $display("[TB] FAIL single_data[%0d]: got v=%b %h required v=1 %h", i, mValid, mPacked, beats[i]);
      end
      checks++;
      if (lineCnt !== expCnt[i]) begin
        errors++;
        $display("[TB] FAIL single_line_cnt[%0d]: got %0d required %0d", i, lineCnt, expCnt[i]);
      end
    end
    checks++;
    if (frameDone !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_done: got done=%b busy=%b required done=1 busy=0", frameDone, busy);
    end
    s0Valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (doneCnt - doneBase !== 1) begin
      errors++;
      $display("[TB] FAIL single_done_count: got %0d required 1", doneCnt - doneBase);
    end
  endtask

  task automatic test_contention();
    doReset();
    s1Valid = 1'b1; s1Packed = pk(8'hC1, 1, 0);
    applyStimulus(0, pk(8'hB1, 1, 0));
    checks++;
    if (grant !== 1'b0 || mPacked !== pk(8'hB1, 1, 0)) begin
      errors++;
      $display("[TB] FAIL contention_first_grant: got grant=%b %h required grant=0 %h", grant, mPacked, pk(8'hB1, 1, 0));
    end
    applyStimulus(0, pk(8'hB2, 0, 1));
    checks++;
    if (s1Ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL contention_s1_stall: got s1 tready=%b required 0", s1Ready);
    end
    applyStimulus(0, pk(8'hB3, 0, 1));
    checks++;
    if (frameDone !== 1'b1 || s1Ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL contention_s0_done: got done=%b s1 tready=%b required done=1 tready=0", frameDone, s1Ready);
    end
    s0Valid = 1'b0;
    applyStimulus(1, pk(8'hC1, 1, 0));
    checks++;
    if (grant !== 1'b1 || mPacked !== pk(8'hC1, 1, 0)) begin
      errors++;
      $display("[TB] FAIL contention_second_grant: got grant=%b %h required grant=1 %h", grant, mPacked, pk(8'hC1, 1, 0));
    end
    applyStimulus(1, pk(8'hC2, 0, 1));
    applyStimulus(1, pk(8'hC3, 0, 1));
    s0Valid = 1'b1; s0Packed = pk(8'hB4, 1, 0);
    s1Valid = 1'b1; s1Packed = pk(8'hC4, 1, 0);
    @(posedge clk);
    #1;
    checks++;
    if (grant !== 1'b0 || busy !== 1'b1 || s1Ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL contention_rotate: got grant=%b busy=%b s1 tready=%b required 0 1 0", grant, busy, s1Ready);
    end
  endtask

  task automatic test_resync();
    int dropBase;
    doReset();
    dropBase = dropCnt;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, pk(8'hD0 + 8'(i), 0, 0));
      checks++;
      if (drop !== 1'b1 || mValid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL resync_drop[%0d]: got drop=%b mvalid=%b required drop=1 mvalid=0", i, drop, mValid);
      end
    end
    applyStimulus(1, pk(8'hE1, 1, 0));
    checks++;
    if (grant !== 1'b1 || mPacked !== pk(8'hE1, 1, 0)) begin
      errors++;
      $display("[TB] FAIL resync_grant: got grant=%b %h required grant=1 %h", grant, mPacked, pk(8'hE1, 1, 0));
    end
    checks++;
    if (dropCnt - dropBase !== 3) begin
      errors++;
      $display("[TB] FAIL resync_drop_count: got %0d required 3", dropCnt - dropBase);
    end
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] exp[4];
    int monBase;
    doReset();
    monBase = monQ.size();
    exp[0] = pk(8'hF1, 1, 0); exp[1] = pk(8'hF2, 0, 1);
    exp[2] = pk(8'hF3, 0, 0); exp[3] = pk(8'hF4, 0, 1);
    mReady = 1'b0;
    applyStimulus(0, exp[0]);
    s0Packed = exp[1];
    mReady = 1'b1;
    #1;
    checks++;
    if (s0Ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_ready_open: got %b required 1", s0Ready);
    end
    @(posedge clk);
    #1;
    s0Packed = exp[2];
    mReady = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (s0Ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_ready_stall[%0d]: got %b required 0", i, s0Ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (mValid !== 1'b1 || mPacked !== exp[1]) begin
        errors++;
        $display("[TB] FAIL bp_hold[%0d]: got v=%b %h required v=1 %h", i, mValid, mPacked, exp[1]);
      end
    end
    mReady = 1'b1;
    #1;
    checks++;
    if (s0Ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_ready_resume: got %b required 1", s0Ready);
    end
    @(posedge clk);
    #1;
    applyStimulus(0, exp[3]);
    s0Valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (monQ.size() - monBase !== 4) begin
      errors++;
      $display("[TB] FAIL bp_beat_count: got %0d required 4", monQ.size() - monBase);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (monQ[monBase + i] !== exp[i]) begin
          errors++;
          $display("[TB] FAIL bp_order[%0d]: got %h required %h", i, monQ[monBase + i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_mid_sof();
    doReset();
    applyStimulus(0, pk(8'h11, 1, 0));
    applyStimulus(0, pk(8'h12, 0, 1));
    applyStimulus(0, pk(8'h13, 1, 0));
`ifdef PACKED_ARB_SOF_CHECK_EN
    checks++;
    if (err !== 1'b1 || lineCnt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midsof_restart: got err=%b cnt=%0d required err=1 cnt=0", err, lineCnt);
    end
    applyStimulus(0, pk(8'h14, 0, 1));
    checks++;
    if (frameDone !== 1'b0 || busy !== 1'b1 || lineCnt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midsof_continue: got done=%b busy=%b cnt=%0d required 0 1 1", frameDone, busy, lineCnt);
    end
    applyStimulus(0, pk(8'h15, 0, 1));
`else
    checks++;
    if (err !== 1'b0 || lineCnt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midsof_ignored: got err=%b cnt=%0d required err=0 cnt=1", err, lineCnt);
    end
    applyStimulus(0, pk(8'h14, 0, 1));
`endif
    checks++;
    if (frameDone !== 1'b1 || lineCnt !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midsof_done: got done=%b cnt=%0d busy=%b required 1 0 0", frameDone, lineCnt, busy);
    end
    s0Valid = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    doReset();
    applyStimulus(0, pk(8'h21, 1, 0));
    mReady = 1'b0;
    s0Packed = pk(8'h22, 0, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({mValid, mPacked, lineCnt, grant, busy, frameDone, drop, err} !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got %b required all zero",
               {mValid, mPacked, lineCnt, grant, busy, frameDone, drop, err});
    end
    s0Valid = 1'b0;
    mReady = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(0, pk(8'h23, 0, 1));
    checks++;
    if (drop !== 1'b1 || busy !== 1'b0 || mValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_no_regrant: got drop=%b busy=%b mvalid=%b required 1 0 0", drop, busy, mValid);
    end
    applyStimulus(0, pk(8'h24, 1, 0));
    checks++;
    if (busy !== 1'b1 || grant !== 1'b0 || mPacked !== pk(8'h24, 1, 0)) begin
      errors++;
      $display("[TB] FAIL midreset_regrant: got busy=%b grant=%b %h required 1 0 %h", busy, grant, mPacked, pk(8'h24, 1, 0));
    end
    s0Valid = 1'b0;
  endtask

  initial begin
    $display("[TB] starting axis_packed_frame_arb bench");
    test_reset();
    test_single();
    test_contention();
    test_resync();
    test_backpressure();
    test_mid_sof();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
